// File: rtl/fir_cap_pkg.sv
// fir_cap_pkg: shared constants for the FIR output capture buffer.
//   FIR_CAP_N / FIR_CAP_ADDR : default sample width and address width
//   FIR_CAP_DEPTH            : buffer depth (2**FIR_CAP_ADDR)
//   S_*                      : capture FSM state encoding
package fir_cap_pkg;

   localparam int unsigned FIR_CAP_N     = 16;
   localparam int unsigned FIR_CAP_ADDR  = 5;
   localparam int unsigned FIR_CAP_DEPTH = 2 ** FIR_CAP_ADDR;

   localparam int unsigned ST_W = 2;

   localparam logic [ST_W-1:0] S_IDLE    = 2'd0;
   localparam logic [ST_W-1:0] S_ARMED   = 2'd1;
   localparam logic [ST_W-1:0] S_CAPTURE = 2'd2;
   localparam logic [ST_W-1:0] S_DONE    = 2'd3;

endpackage

// File: rtl/fir_cap_ram.sv
// fir_cap_ram: DEPTH x N sample store, one write port, one synchronous read port.
//   clk, rst_n            : clock, async active-low reset (read register only)
//   wr_en_i/addr/data     : write port, written on the rising edge
//   rd_en_i, rd_addr_i    : read request, data appears after the edge
//   rd_data_o             : registered read data, holds when no read
module fir_cap_ram
   import fir_cap_pkg::*;
#(
   parameter int unsigned N    = FIR_CAP_N,
   parameter int unsigned ADDR = FIR_CAP_ADDR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en_i,
   input  logic [ADDR-1:0] wr_addr_i,
   input  logic [N-1:0]    wr_data_i,
   input  logic            rd_en_i,
   input  logic [ADDR-1:0] rd_addr_i,
   output logic [N-1:0]    rd_data_o
);

   localparam int unsigned DEPTH = 2 ** ADDR;

   logic [N-1:0] mem [DEPTH];
   logic [N-1:0] rd_data_q;

   // Storage array: deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   // Read register clears on reset so the output is defined before any read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_capture_buffer.sv
// fir_capture_buffer: captures a DEPTH-sample burst of FIR output and
// serves it back by address once the buffer is full.
//   Clk, Rst_n            : clock, async active-low reset
//   Start                 : arm/capture request (honoured in IDLE or DONE)
//   Din, Din_valid        : filter output sample stream
//   Threshold             : unsigned magnitude trigger level
//   Busy, Done, Wr_count  : capture status
//   Rd_en, Rd_addr        : read request (honoured in DONE only)
//   Rd_data, Rd_valid     : read response, one cycle after the request
// Build option FIR_CAP_TRIG_EN: adds the ARMED state, in which capture waits
// for the first valid sample with |Din| >= Threshold.
module fir_capture_buffer
   import fir_cap_pkg::*;
#(
   parameter int unsigned N    = FIR_CAP_N,
   parameter int unsigned ADDR = FIR_CAP_ADDR
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            Start,
   input  logic [N-1:0]    Din,
   input  logic            Din_valid,
   input  logic [N-1:0]    Threshold,
   output logic            Busy,
   output logic            Done,
   output logic [ADDR:0]   Wr_count,
   input  logic            Rd_en,
   input  logic [ADDR-1:0] Rd_addr,
   output logic [N-1:0]    Rd_data,
   output logic            Rd_valid
);

   localparam int unsigned DEPTH = 2 ** ADDR;
   localparam int unsigned CW    = ADDR + 1;

`ifdef FIR_CAP_TRIG_EN
   localparam logic [ST_W-1:0] START_ST = S_ARMED;
`else
   localparam logic [ST_W-1:0] START_ST = S_CAPTURE;
`endif

   logic [ST_W-1:0] state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            rd_valid_q;
   logic            wr_en_c;
   logic            rd_en_c;
   logic            trig_c;

`ifdef FIR_CAP_TRIG_EN
   // Two's-complement magnitude as unsigned N bits; the most negative value
   // maps to 2**(N-1), which is exactly its bit pattern.
   logic [N-1:0] mag_c;
   assign mag_c  = Din[N-1] ? N'((~Din) + N'(1)) : Din;
   assign trig_c = Din_valid && (mag_c >= Threshold);
`else
   logic thr_unused_c;
   assign thr_unused_c = ^Threshold;
   assign trig_c       = 1'b0;
`endif

   // Reads are only served from a completed buffer.
   assign rd_en_c = Rd_en && (state_q == S_DONE);

   // Next-state, pointer and write-enable logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en_c = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               cnt_d   = '0;
               state_d = START_ST;
            end
         end
         S_ARMED: begin
            // Trigger sample is stored on the same edge it is detected.
            if (trig_c) begin
               wr_en_c = 1'b1;
               cnt_d   = CW'(1);
               state_d = S_CAPTURE;
            end
`ifndef FIR_CAP_TRIG_EN
            state_d = S_IDLE;
`endif
         end
         S_CAPTURE: begin
            if (Din_valid) begin
               wr_en_c = 1'b1;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(DEPTH - 1)) begin
                  state_d = S_DONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
      done_d = (state_d == S_DONE);
   end

   // State and status registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_valid_q <= rd_en_c;
      end
   end

   // Low count bits double as the write pointer; they wrap to 0 at DEPTH.
   fir_cap_ram #(
      .N    (N),
      .ADDR (ADDR)
   ) u_ram (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .wr_en_i   (wr_en_c),
      .wr_addr_i (cnt_q[ADDR-1:0]),
      .wr_data_i (Din),
      .rd_en_i   (rd_en_c),
      .rd_addr_i (Rd_addr),
      .rd_data_o (Rd_data)
   );

   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Wr_count = cnt_q;
   assign Rd_valid = rd_valid_q;

endmodule

// File: tb/tb_fir_capture_buffer.sv
// tb_fir_capture_buffer: directed bench with a read-data scoreboard.
module tb_fir_capture_buffer;

   localparam int unsigned N     = 16;
   localparam int unsigned ADDR  = 5;
   localparam int unsigned DEPTH = 32;

   logic            Clk = 1'b0;
   logic            Rst_n;
   logic            Start;
   logic [N-1:0]    Din;
   logic            Din_valid;
   logic [N-1:0]    Threshold;
   logic            Busy;
   logic            Done;
   logic [ADDR:0]   Wr_count;
   logic            Rd_en;
   logic [ADDR-1:0] Rd_addr;
   logic [N-1:0]    Rd_data;
   logic            Rd_valid;

   int errors = 0;
   int checks = 0;
   logic [N-1:0] exp_q [$];

   fir_capture_buffer #(.N(N), .ADDR(ADDR)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Start     (Start),
      .Din       (Din),
      .Din_valid (Din_valid),
      .Threshold (Threshold),
      .Busy      (Busy),
      .Done      (Done),
      .Wr_count  (Wr_count),
      .Rd_en     (Rd_en),
      .Rd_addr   (Rd_addr),
      .Rd_data   (Rd_data),
      .Rd_valid  (Rd_valid)
   );

   always #5 Clk = ~Clk;

   // Monitor: every Rd_valid pulse must match the oldest outstanding read.
   always @(negedge Clk) begin
      if (Rst_n && Rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: Rd_valid=1 data=%0h with no read outstanding", Rd_data);
         end else begin
            logic [N-1:0] e;
            e = exp_q.pop_front();
            if (Rd_data !== e) begin
               errors++;
               $display("FAIL rd_data: got %0h expected %0h", Rd_data, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      Start     = 1'b0;
      Din_valid = 1'b0;
      Din       = 16'hDEAD;
      Rd_en     = 1'b0;
      Rd_addr   = '0;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   // Drive n valid samples base, base+1, ... on consecutive cycles.
   task automatic feed(input int base, input int n);
      for (int j = 0; j < n; j++) begin
         Din       = N'(base + j);
         Din_valid = 1'b1;
         tick();
      end
      Din_valid = 1'b0;
      Din       = 16'hDEAD;
   endtask

   // Issue one read and record its expected data; leaves Rd_en asserted.
   task automatic rd(input int addr, input logic [N-1:0] exp);
      Rd_en   = 1'b1;
      Rd_addr = ADDR'(addr);
      exp_q.push_back(exp);
      tick();
   endtask

   task automatic drain();
      Rd_en = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      idle_inputs();
      Threshold = '0;
      Rst_n     = 1'b0;

      // Reset state.
      tick(); tick();
      chk("rst_busy",     32'(Busy),     32'd0);
      chk("rst_done",     32'(Done),     32'd0);
      chk("rst_rd_valid", 32'(Rd_valid), 32'd0);
      chk("rst_wr_count", 32'(Wr_count), 32'd0);
      chk("rst_rd_data",  32'(Rd_data),  32'd0);
      Rst_n = 1'b1;
      tick();

      // Contiguous burst of 1..32.
      pulse_start();
      chk("start_busy",  32'(Busy),     32'd1);
      chk("start_count", 32'(Wr_count), 32'd0);
      feed(1, 31);
      chk("b1_count31", 32'(Wr_count), 32'd31);
      chk("b1_done31",  32'(Done),     32'd0);
      feed(32, 1);
      chk("b1_done",  32'(Done),     32'd1);
      chk("b1_busy",  32'(Busy),     32'd0);
      chk("b1_count", 32'(Wr_count), 32'd32);
      feed(77, 2);
      chk("b1_count_after_full", 32'(Wr_count), 32'd32);
      rd(5, 16'd6);
      Rd_en = 1'b0;
      tick();
      chk("rd_valid_pulse", 32'(Rd_valid), 32'd0);
      chk("rd_data_hold",   32'(Rd_data),  32'd6);
      rd(0, 16'd1);
      rd(31, 16'd32);
      rd(17, 16'd18);
      drain();

      // Gapped valid: only valid cycles store; invalid cycles carry junk.
      pulse_start();
      for (int k = 0; k < 70; k++) begin
         Din_valid = (k % 2) == 0;
         Din       = Din_valid ? N'(1000 + k / 2) : 16'hBEEF;
         tick();
      end
      idle_inputs();
      chk("gap_done",  32'(Done),     32'd1);
      chk("gap_count", 32'(Wr_count), 32'd32);
      for (int a = 0; a < DEPTH; a++) begin
         rd(a, N'(1000 + a));
      end
      drain();

      // Start together with a read in DONE: read returns old burst data.
      Start = 1'b1;
      rd(3, 16'd1003);
      Start = 1'b0;
      Rd_en = 1'b0;
      chk("sr_busy",  32'(Busy),     32'd1);
      chk("sr_count", 32'(Wr_count), 32'd0);
      tick();
      // Start and read issued during capture are ignored.
      feed(500, 10);
      chk("cap_count10", 32'(Wr_count), 32'd10);
      Start = 1'b1;
      Rd_en = 1'b1;
      Rd_addr = 5'd2;
      feed(510, 1);
      Start = 1'b0;
      Rd_en = 1'b0;
      chk("cap_start_ignored", 32'(Wr_count), 32'd11);
      chk("cap_rd_valid",      32'(Rd_valid), 32'd0);
      chk("cap_busy",          32'(Busy),     32'd1);
      feed(511, 21);
      chk("cap_done",  32'(Done),     32'd1);
      chk("cap_count", 32'(Wr_count), 32'd32);
      rd(0, 16'd500);
      rd(10, 16'd510);
      rd(31, 16'd531);
      drain();

      // Reset mid-burst, then a fresh burst.
      pulse_start();
      feed(700, 17);
      chk("mid_count17", 32'(Wr_count), 32'd17);
      Rst_n = 1'b0;
      #2;
      chk("mid_rst_count", 32'(Wr_count), 32'd0);
      chk("mid_rst_busy",  32'(Busy),     32'd0);
      chk("mid_rst_done",  32'(Done),     32'd0);
      Rst_n = 1'b1;
      tick();
      pulse_start();
      feed(900, 32);
      chk("fresh_done",  32'(Done),     32'd1);
      chk("fresh_count", 32'(Wr_count), 32'd32);
      rd(0, 16'd900);
      rd(16, 16'd916);
      rd(31, 16'd931);
      drain();

`ifdef FIR_CAP_TRIG_EN
      // Magnitude trigger: -120 is the first sample with |x| >= 100.
      Threshold = 16'd100;
      pulse_start();
      chk("trig_armed_busy", 32'(Busy), 32'd1);
      feed(10, 1);
      Din = 16'hFFCE; Din_valid = 1'b1; tick();
      chk("trig_wait_count", 32'(Wr_count), 32'd0);
      Din = 16'hFF88; tick();
      chk("trig_hit_count", 32'(Wr_count), 32'd1);
      Din = 16'd7; tick();
      chk("trig_next_count", 32'(Wr_count), 32'd2);
      feed(40, 30);
      chk("trig_done", 32'(Done), 32'd1);
      rd(0, 16'hFF88);
      rd(1, 16'd7);
      drain();
`endif

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rd_missing: got %0d outstanding reads expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
